// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single valid/ready memory slave.
// The grant is held for a whole transaction; a watchdog aborts transactions the slave never completes.
module mem_bus_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant_id,
  output logic              timeout_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT0 = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_ABORT0 = 3'd3,
    ST_ABORT1 = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant_id;
  logic             r_timeout_err;

  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;

  // Arbitration, grant hold and watchdog; a tie goes to the master not served last.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_grant_id    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (m0_valid && (!m1_valid || r_last_grant)) begin
            r_state    <= ST_GRANT0;
            r_grant_id <= 1'b0;
          end else if (m1_valid) begin
            r_state    <= ST_GRANT1;
            r_grant_id <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          // Completion on the last counted cycle wins over the abort.
          if (s_ready) begin
            r_state      <= ST_IDLE;
            r_last_grant <= (r_state == ST_GRANT1);
            r_cnt        <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= (r_state == ST_GRANT1) ? ST_ABORT1 : ST_ABORT0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ABORT0, ST_ABORT1: begin
          r_state       <= ST_IDLE;
          r_last_grant  <= (r_state == ST_ABORT1);
          r_timeout_err <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Bus muxing from the current state; idle and abort states keep the slave request low.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = 4'b0000;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    case (r_state)
      ST_GRANT0: begin
        s_valid  = m0_valid;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
      end
      ST_GRANT1: begin
        s_valid  = m1_valid;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
      end
      ST_ABORT0: begin
        m0_ready = 1'b1;
        m0_rdata = TIMEOUT_RDATA;
      end
      ST_ABORT1: begin
        m1_ready = 1'b1;
        m1_rdata = TIMEOUT_RDATA;
      end
      default: begin
        s_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: master drivers, a BRAM-like slave model
// (ready in the 4th cycle of a request) and a monitor that pops expected completions.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int SLV_LAT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mv [2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] mw [2];
  logic [3:0] ms [2];
  logic m0_ready, m1_ready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic s_valid, s_ready;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic grant_id, timeout_err;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { int id; logic [31:0] rdata; bit chk_rdata; int lat; } exp_t;

  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int start_cyc [2];
  bit kill [2];
  bit stall = 1'b0;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] rdata, input bit chk_rd, input int lat);
    exp_t e;
    e.id = id; e.rdata = rdata; e.chk_rdata = chk_rd; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic push_req(input int id, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    if (id == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Master driver: holds valid with one request until its ready pulse, then presents the next.
  task automatic drive(input int id);
    req_t r;
    int n;
    bit done;
    forever begin
      @(posedge clk); #1;
      while ((id == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
        if (id == 0) r = q0.pop_front();
        else r = q1.pop_front();
        mv[id] = 1'b1; ma[id] = r.addr; mw[id] = r.wdata; ms[id] = r.wstrb;
        start_cyc[id] = cyc;
        n = 0; done = 1'b0;
        while (!done) begin
          @(negedge clk);
          if (((id == 0) ? m0_ready : m1_ready) || kill[id]) done = 1'b1;
          else if (++n > 100) begin
            checks++; failures++;
            $display("FAIL master%0d_ready_timeout actual=no_ready expected=ready_within_100", id);
            done = 1'b1;
          end
        end
        @(posedge clk); #1;
      end
      mv[id] = 1'b0; ma[id] = '0; mw[id] = '0; ms[id] = 4'b0000;
    end
  endtask

  initial drive(0);
  initial drive(1);

  // Slave model: unwritten words read back as addr>>2.
  initial begin
    int lat;
    logic [31:0] w;
    lat = 0; s_ready = 1'b0; s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (s_ready) begin
        s_ready = 1'b0; s_rdata = '0; lat = 0;
      end else if (s_valid && !stall) begin
        lat++;
        if (lat == SLV_LAT) begin
          s_ready = 1'b1;
          w = mem.exists(s_addr) ? mem[s_addr] : (s_addr >> 2);
          if (s_wstrb != 4'b0000) begin
            for (int b = 0; b < 4; b++) if (s_wstrb[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
            mem[s_addr] = w;
            s_rdata = '0;
          end else begin
            s_rdata = w;
          end
        end
      end else if (!s_valid) begin
        lat = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ready pulse and checks the one-cycle idle gap.
  initial begin
    bit prev_rdy;
    exp_t e;
    int id;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_rdy) chk("idle_gap_s_valid", {31'b0, s_valid}, 32'd0);
      prev_rdy = m0_ready || m1_ready;
      if (m0_ready || m1_ready) begin
        chk("ready_onehot", {31'b0, m0_ready & m1_ready}, 32'd0);
        id = m1_ready ? 1 : 0;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready actual=master%0d expected=none", id);
        end else begin
          e = sb.pop_front();
          chk("grant_order", id, e.id);
          chk("grant_id_at_ready", {31'b0, grant_id}, e.id);
          if (e.chk_rdata) chk("rdata", (id == 0) ? m0_rdata : m1_rdata, e.rdata);
          if (e.lat >= 0) chk("latency", cyc - start_cyc[id], e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || mv[0] || mv[1]) && n < 500) begin
      @(posedge clk); n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=pending=%0d expected=0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = 4'b0000; kill[i] = 1'b0; start_cyc[i] = 0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_wstrb", {28'b0, s_wstrb}, 32'd0);
    chk("rst_grant_id", {31'b0, grant_id}, 32'd0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);

    // Tie right after reset, then strict alternation with continuous re-requests.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push_req(0, 32'h0 + 32'(4 * i), 32'h0, 4'b0000);
      push_req(1, 32'h100 + 32'(4 * i), 32'h0, 4'b0000);
      push_exp(0, 32'(i), 1'b1, -1);
      push_exp(1, 32'h40 + 32'(i), 1'b1, -1);
    end
    reset_n = 1'b1;
    wait_idle();

    // Single read of 0x10 by master 0.
    push_req(0, 32'h10, 32'h0, 4'b0000);
    push_exp(0, 32'h4, 1'b1, 4);
    wait_idle();

    // Master 1 write then read back.
    push_req(1, 32'h80, 32'hCAFE_F00D, 4'b1111);
    push_req(1, 32'h80, 32'h0, 4'b0000);
    push_exp(1, 32'h0, 1'b0, 4);
    push_exp(1, 32'hCAFE_F00D, 1'b1, -1);
    wait_idle();
    chk("grant_id_after_m1", {31'b0, grant_id}, 32'd1);

    // Watchdog abort on master 0, then a normal master 1 read.
    stall = 1'b1;
    push_req(0, 32'h20, 32'h0, 4'b0000);
    push_exp(0, 32'hDEAD_BEEF, 1'b1, TO + 1);
    wait_idle();
    chk("timeout_err_set", {31'b0, timeout_err}, 32'd1);
    stall = 1'b0;
    push_req(1, 32'h30, 32'h0, 4'b0000);
    push_exp(1, 32'hC, 1'b1, 4);
    wait_idle();
    chk("timeout_err_sticky", {31'b0, timeout_err}, 32'd1);

    // Reset in the middle of a master 1 transaction.
    stall = 1'b1;
    push_req(1, 32'h44, 32'h0, 4'b0000);
    repeat (4) @(posedge clk);
    #2;
    chk("mid_grant_id", {31'b0, grant_id}, 32'd1);
    chk("mid_s_valid", {31'b0, s_valid}, 32'd1);
    reset_n = 1'b0;
    kill[1] = 1'b1;
    @(posedge clk);
    #2;
    chk("mrst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("mrst_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("mrst_timeout_err", {31'b0, timeout_err}, 32'd0);
    chk("mrst_grant_id", {31'b0, grant_id}, 32'd0);
    reset_n = 1'b1;
    stall = 1'b0;
    repeat (4) @(posedge clk);
    kill[1] = 1'b0;

    // Recovery after reset.
    push_req(0, 32'h8, 32'h0, 4'b0000);
    push_exp(0, 32'h2, 1'b1, 4);
    wait_idle();

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
